// File: rtl/ledger_pkg.sv
// ---------------------------------------------------------------------------
// ledger_pkg
// Shared definitions for the ledger update controller and its transfer ALU.
// Contents:
//   BAL_W, NUM_ACCT, IDX_W, WORD_W - ledger word geometry
//   TIMEOUT_DEFAULT, WD_W          - watchdog limit and counter width
//   proc_t                          - controller states, which are also the
//                                     phase codes driven onto 'process'
//   field_lsb()                     - bit offset of an account in the word
// ---------------------------------------------------------------------------
package ledger_pkg;

    localparam int BAL_W           = 16;
    localparam int NUM_ACCT        = 3;
    localparam int IDX_W           = 2;
    localparam int WORD_W          = BAL_W * NUM_ACCT;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WD_W            = 8;

    // The state encoding doubles as the phase code seen by memory_control,
    // so these values must not be reordered.
    typedef enum logic [2:0] {
        PROC_IDLE    = 3'b000,
        PROC_REQUEST = 3'b001,
        PROC_CAPTURE = 3'b010,
        PROC_CHECK   = 3'b011,
        PROC_COMMIT  = 3'b100,
        PROC_REPORT  = 3'b101
    } proc_t;

    // Account idx occupies bits [idx*width +: width] of the ledger word.
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ledger_transfer_alu.sv
// ---------------------------------------------------------------------------
// ledger_transfer_alu
// Purely combinational validation and update of one transfer against a
// packed ledger word.
// Ports:
//   word      in  packed balances, account i at [i*W +: W]
//   sender    in  source account index
//   receiver  in  destination account index
//   amount    in  transfer amount
//   ok        out transfer is legal and applied
//   new_word  out updated word when ok, otherwise word unchanged
// ---------------------------------------------------------------------------
module ledger_transfer_alu
    import ledger_pkg::*;
#(
    parameter int W  = BAL_W,
    parameter int N  = NUM_ACCT,
    parameter int IW = IDX_W
) (
    input  logic [W*N-1:0] word,
    input  logic [IW-1:0]  sender,
    input  logic [IW-1:0]  receiver,
    input  logic [W-1:0]   amount,
    output logic           ok,
    output logic [W*N-1:0] new_word
);

    logic [W-1:0] bal_s;
    logic [W-1:0] bal_r;
    logic [W:0]   sum_r;
    logic         idx_ok;

    // Balances are selected by compare-per-account rather than by a variable
    // part-select so an out-of-range index can never address outside the word.
    // The receiver sum keeps one extra bit; its carry marks an overflow.
    always_comb begin
        bal_s    = '0;
        bal_r    = '0;
        new_word = word;
        for (int i = 0; i < N; i++) begin
            if (sender == IW'(i)) begin
                bal_s = word[field_lsb(i, W) +: W];
            end
            if (receiver == IW'(i)) begin
                bal_r = word[field_lsb(i, W) +: W];
            end
        end
        idx_ok = (32'(sender) < 32'(N)) && (32'(receiver) < 32'(N));
        sum_r  = {1'b0, bal_r} + {1'b0, amount};
        ok     = idx_ok && (sender != receiver) && (amount <= bal_s) && !sum_r[W];
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                if (sender == IW'(i)) begin
                    new_word[field_lsb(i, W) +: W] = bal_s - amount;
                end
                if (receiver == IW'(i)) begin
                    new_word[field_lsb(i, W) +: W] = sum_r[W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/ledger_update_control.sv
// ---------------------------------------------------------------------------
// ledger_update_control
// Transaction controller in front of memory_control. Takes one transfer
// request, has memory_control read the ledger word, validates and applies the
// transfer, hands the resulting word back for write-back and reports the
// outcome. A refused transfer writes back the unchanged word so the memory
// side always completes its cycle.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   submit           request strobe, honoured only in IDLE
//   sender/receiver  account indices of the request
//   amount           transfer amount
//   finished_init    memory_control has initialised the ledger
//   done             memory_control idle in its buffer state
//   load_registers   memory read data valid
//   mem_data         ledger word from memory
//   load_memory      read request to memory_control
//   process          phase code (equals controller state)
//   datapath_out     word to write back
//   busy             controller not in IDLE
//   accepted         one-cycle pulse, transfer applied
//   rejected         one-cycle pulse, transfer refused
//   timeout_err      sticky watchdog error
// All outputs are registered.
// ---------------------------------------------------------------------------
module ledger_update_control
    import ledger_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              submit,
    input  logic [IDX_W-1:0]  sender,
    input  logic [IDX_W-1:0]  receiver,
    input  logic [BAL_W-1:0]  amount,
    input  logic              finished_init,
    input  logic              done,
    input  logic              load_registers,
    input  logic [WORD_W-1:0] mem_data,
    output logic              load_memory,
    output logic [2:0]        process,
    output logic [WORD_W-1:0] datapath_out,
    output logic              busy,
    output logic              accepted,
    output logic              rejected,
    output logic              timeout_err
);

    proc_t             state_q, state_d;
    logic [IDX_W-1:0]  sender_q, sender_d;
    logic [IDX_W-1:0]  receiver_q, receiver_d;
    logic [BAL_W-1:0]  amount_q, amount_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              seen_low_q, seen_low_d;
    logic              ok_q, ok_d;
    logic              load_memory_q, load_memory_d;
    logic [WORD_W-1:0] datapath_out_q, datapath_out_d;
    logic              busy_q, busy_d;
    logic              accepted_q, accepted_d;
    logic              rejected_q, rejected_d;
    logic              timeout_err_q, timeout_err_d;

    logic              timeout_hit;
    logic              wd_active;
    logic              alu_ok;
    logic [WORD_W-1:0] alu_new_word;

    ledger_transfer_alu #(
        .W  (BAL_W),
        .N  (NUM_ACCT),
        .IW (IDX_W)
    ) u_alu (
        .word     (word_q),
        .sender   (sender_q),
        .receiver (receiver_q),
        .amount   (amount_q),
        .ok       (alu_ok),
        .new_word (alu_new_word)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= PROC_IDLE;
            sender_q       <= '0;
            receiver_q     <= '0;
            amount_q       <= '0;
            word_q         <= '0;
            wd_cnt_q       <= '0;
            seen_low_q     <= 1'b0;
            ok_q           <= 1'b0;
            load_memory_q  <= 1'b0;
            datapath_out_q <= '0;
            busy_q         <= 1'b0;
            accepted_q     <= 1'b0;
            rejected_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sender_q       <= sender_d;
            receiver_q     <= receiver_d;
            amount_q       <= amount_d;
            word_q         <= word_d;
            wd_cnt_q       <= wd_cnt_d;
            seen_low_q     <= seen_low_d;
            ok_q           <= ok_d;
            load_memory_q  <= load_memory_d;
            datapath_out_q <= datapath_out_d;
            busy_q         <= busy_d;
            accepted_q     <= accepted_d;
            rejected_q     <= rejected_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Next-state logic plus request/word capture. The watchdog overrides a
    // stalled state only when no normal transition is taken that cycle; the
    // counter restarts on every state change so each waiting state gets its
    // own full budget.
    always_comb begin
        state_d        = state_q;
        sender_d       = sender_q;
        receiver_d     = receiver_q;
        amount_d       = amount_q;
        word_d         = word_q;
        seen_low_d     = seen_low_q;
        ok_d           = ok_q;
        datapath_out_d = datapath_out_q;
        timeout_hit    = 1'b0;
        wd_active      = (state_q == PROC_REQUEST) || (state_q == PROC_CAPTURE) ||
                         (state_q == PROC_COMMIT);

        case (state_q)
            PROC_IDLE: begin
                if (submit && finished_init && done) begin
                    sender_d   = sender;
                    receiver_d = receiver;
                    amount_d   = amount;
                    state_d    = PROC_REQUEST;
                end
            end
            PROC_REQUEST: begin
                if (load_registers) begin
                    word_d  = mem_data;
                    state_d = PROC_CAPTURE;
                end
            end
            PROC_CAPTURE: begin
                if (load_registers) begin
                    word_d = mem_data;
                end else begin
                    state_d = PROC_CHECK;
                end
            end
            PROC_CHECK: begin
                ok_d           = alu_ok;
                datapath_out_d = alu_new_word;
                state_d        = PROC_COMMIT;
            end
            PROC_COMMIT: begin
                if (!done) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = PROC_REPORT;
                end
            end
            PROC_REPORT: begin
                state_d = PROC_IDLE;
            end
            default: begin
                state_d = PROC_IDLE;
            end
        endcase

        if (wd_active && (state_d == state_q) &&
            (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
            timeout_hit = 1'b1;
            state_d     = PROC_IDLE;
        end

        if (state_d != state_q) begin
            wd_cnt_d   = '0;
            seen_low_d = 1'b0;
        end else if (wd_active) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
    end

    // Output logic, computed from the upcoming state so every output comes
    // straight from a flop and lines up with the state it belongs to.
    always_comb begin
        load_memory_d = (state_d == PROC_REQUEST);
        busy_d        = (state_d != PROC_IDLE);
        accepted_d    = (state_d == PROC_REPORT) && ok_d;
        rejected_d    = (state_d == PROC_REPORT) && !ok_d;
        timeout_err_d = timeout_err_q;
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end else if ((state_q == PROC_IDLE) && (state_d == PROC_REQUEST)) begin
            timeout_err_d = 1'b0;
        end
    end

    assign load_memory  = load_memory_q;
    assign process      = state_q;
    assign datapath_out = datapath_out_q;
    assign busy         = busy_q;
    assign accepted     = accepted_q;
    assign rejected     = rejected_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ledger_update_control.sv
// ---------------------------------------------------------------------------
// tb_ledger_update_control
// Bench for ledger_update_control with a behavioural memory_control stand-in
// and a transfer reference model written from the ledger rules.
// ---------------------------------------------------------------------------
module tb_ledger_update_control;

    logic        clock;
    logic        reset;
    logic        submit;
    logic [1:0]  sender;
    logic [1:0]  receiver;
    logic [15:0] amount;
    logic        finished_init;
    logic        done;
    logic        load_registers;
    logic [47:0] mem_data;
    logic        load_memory;
    logic [2:0]  process;
    logic [47:0] datapath_out;
    logic        busy;
    logic        accepted;
    logic        rejected;
    logic        timeout_err;

    int          total;
    int          bad;
    logic [47:0] ledger;
    bit          read_en;
    bit          write_en;

    ledger_update_control dut (
        .clock          (clock),
        .reset          (reset),
        .submit         (submit),
        .sender         (sender),
        .receiver       (receiver),
        .amount         (amount),
        .finished_init  (finished_init),
        .done           (done),
        .load_registers (load_registers),
        .mem_data       (mem_data),
        .load_memory    (load_memory),
        .process        (process),
        .datapath_out   (datapath_out),
        .busy           (busy),
        .accepted       (accepted),
        .rejected       (rejected),
        .timeout_err    (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory_control stand-in: answers a read with a two-cycle data burst and
    // a commit with a done low/high handshake, storing the written word.
    initial begin
        load_registers = 1'b0;
        mem_data       = '0;
        done           = 1'b1;
        forever begin
            @(negedge clock);
            if (read_en && load_memory && !reset) begin
                repeat (3) @(negedge clock);
                mem_data       = ledger;
                load_registers = 1'b1;
                repeat (2) @(negedge clock);
                load_registers = 1'b0;
            end else if (write_en && process == 3'b100 && !reset) begin
                repeat (2) @(negedge clock);
                done = 1'b0;
                repeat (3) @(negedge clock);
                ledger = datapath_out;
                done   = 1'b1;
                for (int i = 0; i < 10 && process == 3'b100; i++) @(negedge clock);
            end
        end
    end

    // Reference: apply the transfer rules to the three balances as integers.
    function automatic void refModel(input logic [47:0] w, input int s, input int r,
                                     input int a, output logic [47:0] nw, output bit ok);
        int unsigned b[3];
        for (int i = 0; i < 3; i++) b[i] = w[i*16 +: 16];
        ok = (s < 3) && (r < 3) && (s != r);
        if (ok) begin
            if (a > b[s]) ok = 0;
            else if (b[r] + a > 65535) ok = 0;
        end
        nw = w;
        if (ok) begin
            b[s] = b[s] - a;
            b[r] = b[r] + a;
            nw = {16'(b[2]), 16'(b[1]), 16'(b[0])};
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [47:0] observed,
                               input logic [47:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input logic [1:0] r, input logic [15:0] a);
        @(negedge clock);
        submit   = 1'b1;
        sender   = s;
        receiver = r;
        amount   = a;
        @(negedge clock);
        submit = 1'b0;
    endtask

    // Run one transfer end to end; optionally fire a second submit while the
    // controller sits in COMMIT, which must be ignored.
    task automatic runTxn(input string tag, input logic [47:0] start, input logic [1:0] s,
                          input logic [1:0] r, input logic [15:0] a, input bit extra);
        logic [47:0] exp_word;
        bit          exp_ok;
        int          acc = 0;
        int          rej = 0;
        int          late = 0;
        bit          finished = 0;
        bit          injected = 0;
        bit          busy_after = 1;
        ledger = start;
        refModel(start, int'(s), int'(r), int'(a), exp_word, exp_ok);
        applyStimulus(s, r, a);
        for (int c = 0; c < 200 && !finished; c++) begin
            @(negedge clock);
            submit = 1'b0;
            if (extra && !injected && process == 3'b100) begin
                submit   = 1'b1;
                injected = 1;
            end
            if (accepted) acc++;
            if (rejected) rej++;
            if (accepted || rejected) begin
                @(negedge clock);
                submit     = 1'b0;
                busy_after = busy;
                if (accepted) acc++;
                if (rejected) rej++;
                finished = 1;
            end
        end
        submit = 1'b0;
        checkOutput({tag, "_finished"}, 48'(finished), 48'd1);
        checkOutput({tag, "_accepted"}, 48'(acc), exp_ok ? 48'd1 : 48'd0);
        checkOutput({tag, "_rejected"}, 48'(rej), exp_ok ? 48'd0 : 48'd1);
        checkOutput({tag, "_word"}, ledger, exp_word);
        checkOutput({tag, "_busy_after"}, 48'(busy_after), 48'd0);
        if (extra) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clock);
                if (load_memory || accepted || rejected || busy) late++;
            end
            checkOutput({tag, "_no_second"}, 48'(late), 48'd0);
        end
    endtask

    initial begin
        int          busy_cycles;
        bit          hit;
        logic [47:0] w;
        logic [1:0]  rs;
        logic [1:0]  rr;
        logic [15:0] ra;

        total = 0;
        bad = 0;
        submit = 1'b0;
        sender = '0;
        receiver = '0;
        amount = '0;
        finished_init = 1'b1;
        ledger = '0;
        read_en = 1;
        write_en = 1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] reset state");
        checkOutput("rst_process", 48'(process), 48'd0);
        checkOutput("rst_load_memory", 48'(load_memory), 48'd0);
        checkOutput("rst_datapath", datapath_out, 48'd0);
        checkOutput("rst_busy", 48'(busy), 48'd0);
        checkOutput("rst_pulses", 48'({accepted, rejected, timeout_err}), 48'd0);

        $display("[TB] directed transfers");
        runTxn("accept", 48'h0000_0010_0064, 2'd0, 2'd1, 16'h0014, 0);
        checkOutput("accept_model_word", ledger, 48'h0000_0024_0050);
        runTxn("funds", 48'h0000_0010_0064, 2'd1, 2'd2, 16'h0011, 0);
        runTxn("bad_index", 48'h0000_0010_0064, 2'd3, 2'd0, 16'h0001, 0);
        runTxn("self", 48'h0000_0010_0064, 2'd2, 2'd2, 16'h0001, 0);
        runTxn("overflow", 48'h0000_FFF0_0020, 2'd0, 2'd1, 16'h0020, 0);
        runTxn("zero_amt", 48'h0000_FFF0_0020, 2'd0, 2'd1, 16'h0000, 0);
        runTxn("exact_bal", 48'h0005_0000_0007, 2'd0, 2'd2, 16'h0007, 0);

        $display("[TB] handshake gating");
        finished_init = 1'b0;
        applyStimulus(2'd0, 2'd1, 16'h0001);
        hit = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (load_memory || busy || accepted || rejected) hit = 1;
        end
        checkOutput("gate_init", 48'(hit), 48'd0);
        finished_init = 1'b1;
        runTxn("second_submit", 48'h0100_0200_0300, 2'd2, 2'd0, 16'h0050, 1);

        $display("[TB] random transfers");
        for (int k = 0; k < 20; k++) begin
            w  = {16'($urandom), 16'($urandom), 16'($urandom)};
            rs = 2'($urandom_range(0, 3));
            rr = 2'($urandom_range(0, 3));
            ra = 16'($urandom) >> $urandom_range(0, 15);
            runTxn("random", w, rs, rr, ra, 0);
        end

        $display("[TB] watchdog");
        read_en = 0;
        applyStimulus(2'd0, 2'd1, 16'h0001);
        busy_cycles = 1;
        hit = 0;
        for (int c = 0; c < 400 && !timeout_err; c++) begin
            @(negedge clock);
            if (busy) busy_cycles++;
            if (accepted || rejected) hit = 1;
        end
        checkOutput("to_flag", 48'(timeout_err), 48'd1);
        checkOutput("to_cycles", 48'(busy_cycles), 48'd255);
        checkOutput("to_process", 48'(process), 48'd0);
        checkOutput("to_load_memory", 48'(load_memory), 48'd0);
        checkOutput("to_no_pulse", 48'(hit), 48'd0);
        read_en = 1;
        runTxn("after_timeout", 48'h0000_0010_0064, 2'd0, 2'd1, 16'h0004, 0);
        checkOutput("to_cleared", 48'(timeout_err), 48'd0);

        $display("[TB] reset during commit");
        write_en = 0;
        ledger = 48'h0000_0010_0064;
        applyStimulus(2'd0, 2'd1, 16'h0004);
        for (int c = 0; c < 60 && process != 3'b100; c++) @(negedge clock);
        checkOutput("rc_in_commit", 48'(process), 48'd4);
        checkOutput("rc_commit_word", datapath_out, 48'h0000_0014_0060);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rc_process", 48'(process), 48'd0);
        checkOutput("rc_outputs", 48'({load_memory, busy, accepted, rejected, timeout_err}), 48'd0);
        checkOutput("rc_datapath", datapath_out, 48'd0);
        reset = 1'b0;
        write_en = 1;
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
